// File: rtl/udp2pcm_if.sv
// UDP header/payload input streams and PCM sample output stream of udp2pcm.
interface udp2pcm_if;
  logic        udp_hdr_valid;
  logic        udp_hdr_ready;
  logic [15:0] udp_length;
  logic [7:0]  udp_payload_axis_tdata;
  logic        udp_payload_axis_tvalid;
  logic        udp_payload_axis_tready;
  logic        udp_payload_axis_tlast;
  logic [15:0] pcm_out;
  logic        pcm_out_valid;
  logic        pcm_out_ready;

  modport master (
    output udp_hdr_valid, udp_length, udp_payload_axis_tdata, udp_payload_axis_tvalid,
           udp_payload_axis_tlast, pcm_out_ready,
    input  udp_hdr_ready, udp_payload_axis_tready, pcm_out, pcm_out_valid
  );

  modport slave (
    input  udp_hdr_valid, udp_length, udp_payload_axis_tdata, udp_payload_axis_tvalid,
           udp_payload_axis_tlast, pcm_out_ready,
    output udp_hdr_ready, udp_payload_axis_tready, pcm_out, pcm_out_valid
  );
endinterface

// File: rtl/udp2pcm.sv
// Parses PCM-over-UDP payloads, validates the packet header and queues
// 16-bit samples in a first-word-fall-through FIFO with status counters.
module udp2pcm #(
  parameter logic [7:0]  PCM_UDP_PACKET_TYPE = 8'he0,
  parameter int unsigned pcmaw               = 10,
  parameter int unsigned MAX_SAMPLES         = 660
) (
  input  logic             clk,
  input  logic             rst,
  udp2pcm_if.slave         bus,
  output logic [7:0]       pcm_rx_channel,
  output logic [23:0]      pcm_rx_total,
  output logic [15:0]      pcm_rx_drop,
  output logic [1:0]       pcm_rx_err,
  input  logic             pcm_rx_clear,
  output logic [pcmaw:0]   pcm_available
);
  localparam int unsigned DEPTH = 1 << pcmaw;
  localparam int unsigned CW    = pcmaw + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHK, S_DATA, S_DROP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [7:0]         chan_q, chan_d;
  logic [7:0]         type_q, type_d;
  logic [9:0]         n_q, n_d;
  logic [9:0]         remaining_q, remaining_d;
  logic [7:0]         hi_q, hi_d;
  logic               phase_q, phase_d;
  logic [7:0]         channel_q, channel_d;
  logic [23:0]        total_q, total_d;
  logic [15:0]        drop_q, drop_d;
  logic [1:0]         err_q, err_d;
  logic               hdr_ready_q, hdr_ready_d;
  logic               tready_q, tready_d;
  logic [pcmaw-1:0]   wr_ptr_q, wr_ptr_d;
  logic [pcmaw-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        mem_q [DEPTH];

  logic               beat_c, last_c, push_c, pop_c, drop_inc_c, accept_c;
  logic [15:0]        sample_c;
  logic [CW-1:0]      free_c;
  logic [7:0]         tdata_c;

  assign tdata_c  = bus.udp_payload_axis_tdata;
  assign last_c   = bus.udp_payload_axis_tlast;
  assign beat_c   = bus.udp_payload_axis_tvalid && tready_q;
  assign pop_c    = out_valid_q && bus.pcm_out_ready;
  assign free_c   = CW'(DEPTH) - count_q;
  assign accept_c = (type_q == PCM_UDP_PACKET_TYPE) && (n_q != 10'd0) &&
                    (32'(n_q) <= MAX_SAMPLES) &&
                    (len_q == 16'({n_q, 1'b0}) + 16'd12) &&
                    (32'(free_c) >= 32'(n_q));

  // Next-state, packet parsing, counters and FIFO pointers
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hdr_cnt_d   = hdr_cnt_q;
    chan_d      = chan_q;
    type_d      = type_q;
    n_d         = n_q;
    remaining_d = remaining_q;
    hi_d        = hi_q;
    phase_d     = phase_q;
    channel_d   = channel_q;
    total_d     = total_q;
    drop_d      = drop_q;
    err_d       = err_q;
    push_c      = 1'b0;
    drop_inc_c  = 1'b0;
    sample_c    = {hi_q, tdata_c};

    case (state_q)
      S_IDLE: begin
        if (hdr_ready_q && bus.udp_hdr_valid) begin
          len_d     = bus.udp_length;
          hdr_cnt_d = 2'd0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (beat_c) begin
          case (hdr_cnt_q)
            2'd0:    chan_d    = tdata_c;
            2'd1:    type_d    = tdata_c;
            2'd2:    n_d[9:8]  = tdata_c[1:0];
            default: n_d[7:0]  = tdata_c;
          endcase
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (last_c) begin
            err_d[0]   = 1'b1;
            drop_inc_c = 1'b1;
            state_d    = S_IDLE;
          end else if (hdr_cnt_q == 2'd3) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept_c) begin
          state_d     = S_DATA;
          channel_d   = chan_q;
          remaining_d = n_q;
          phase_d     = 1'b0;
        end else begin
          state_d    = S_DROP;
          drop_inc_c = 1'b1;
        end
      end
      S_DATA: begin
        if (beat_c) begin
          if (!phase_q) begin
            hi_d    = tdata_c;
            phase_d = 1'b1;
            if (last_c) begin
              err_d[0]   = 1'b1;
              drop_inc_c = 1'b1;
              state_d    = S_IDLE;
            end
          end else begin
            push_c      = 1'b1;
            phase_d     = 1'b0;
            remaining_d = remaining_q - 10'd1;
            if (remaining_q == 10'd1) begin
              if (last_c) begin
                state_d = S_IDLE;
              end else begin
                err_d[1] = 1'b1;
                state_d  = S_DROP;
              end
            end else if (last_c) begin
              err_d[0]   = 1'b1;
              drop_inc_c = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end
      end
      S_DROP: begin
        if (beat_c && last_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Saturating statistics; a clear pulse overrides any same-cycle update
    if (push_c && (total_q != 24'hffffff)) total_d = total_q + 24'd1;
    if (drop_inc_c && (drop_q != 16'hffff)) drop_d = drop_q + 16'd1;
    if (pcm_rx_clear) begin
      total_d = 24'd0;
      drop_d  = 16'd0;
      err_d   = 2'b00;
    end

    hdr_ready_d = (state_d == S_IDLE);
    tready_d    = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_DROP);

    // FIFO; output register bypasses the RAM when the head is written this cycle
    wr_ptr_d    = wr_ptr_q + pcmaw'(push_c);
    rd_ptr_d    = rd_ptr_q + pcmaw'(pop_c);
    count_d     = count_q + CW'(push_c) - CW'(pop_c);
    out_valid_d = (count_d != '0);
    out_d       = (push_c && (wr_ptr_q == rd_ptr_d)) ? sample_c : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= sample_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      hdr_cnt_q   <= '0;
      chan_q      <= '0;
      type_q      <= '0;
      n_q         <= '0;
      remaining_q <= '0;
      hi_q        <= '0;
      phase_q     <= 1'b0;
      channel_q   <= '0;
      total_q     <= '0;
      drop_q      <= '0;
      err_q       <= '0;
      hdr_ready_q <= 1'b0;
      tready_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hdr_cnt_q   <= hdr_cnt_d;
      chan_q      <= chan_d;
      type_q      <= type_d;
      n_q         <= n_d;
      remaining_q <= remaining_d;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
      channel_q   <= channel_d;
      total_q     <= total_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      hdr_ready_q <= hdr_ready_d;
      tready_q    <= tready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.udp_hdr_ready           = hdr_ready_q;
  assign bus.udp_payload_axis_tready = tready_q;
  assign bus.pcm_out                 = out_q;
  assign bus.pcm_out_valid           = out_valid_q;
  assign pcm_rx_channel              = channel_q;
  assign pcm_rx_total                = total_q;
  assign pcm_rx_drop                 = drop_q;
  assign pcm_rx_err                  = err_q;
  assign pcm_available               = count_q;
endmodule

// File: tb/tb_udp2pcm.sv
// Scoreboard bench for udp2pcm: packet-level reference model predicts samples
// and status counters; a monitor compares every popped sample.
module tb_udp2pcm;
  localparam int unsigned PCMAW = 10;
  localparam int DEPTH = 1 << PCMAW;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        pcm_rx_channel;
  logic [23:0]       pcm_rx_total;
  logic [15:0]       pcm_rx_drop;
  logic [1:0]        pcm_rx_err;
  logic              pcm_rx_clear;
  logic [PCMAW:0]    pcm_available;

  udp2pcm_if bus ();

  udp2pcm #(.PCM_UDP_PACKET_TYPE(8'he0), .pcmaw(PCMAW), .MAX_SAMPLES(660)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pcm_rx_channel(pcm_rx_channel), .pcm_rx_total(pcm_rx_total),
    .pcm_rx_drop(pcm_rx_drop), .pcm_rx_err(pcm_rx_err),
    .pcm_rx_clear(pcm_rx_clear), .pcm_available(pcm_available)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_total = 0;
  int          exp_drop = 0;
  logic [1:0]  exp_err = 2'b00;
  logic [7:0]  exp_chan = 8'h00;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: every accepted output sample must be the next expected one
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.pcm_out_valid && bus.pcm_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %h expected none", bus.pcm_out);
        end else begin
          e = exp_q.pop_front();
          check("pcm_out", 32'(bus.pcm_out), 32'(e));
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.pcm_out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic send_hdr(input logic [15:0] len);
    bit hs;
    int t;
    hs = 1'b0;
    t  = 0;
    bus.udp_hdr_valid = 1'b1;
    bus.udp_length    = len;
    while (!hs && t < 2000) begin
      @(negedge clk);
      hs = bus.udp_hdr_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!hs) timeout("hdr_handshake");
    bus.udp_hdr_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input bit gaps);
    bit hs;
    int t;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.udp_payload_axis_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.udp_payload_axis_tvalid = 1'b1;
      bus.udp_payload_axis_tdata  = b[i];
      bus.udp_payload_axis_tlast  = (i == b.size() - 1);
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 5000) begin
        @(negedge clk);
        hs = bus.udp_payload_axis_tready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) begin
        timeout("payload_byte");
        break;
      end
    end
    bus.udp_payload_axis_tvalid = 1'b0;
    bus.udp_payload_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 5000) begin
      @(negedge clk);
      if (bus.udp_hdr_ready) break;
      t++;
    end
    if (!bus.udp_hdr_ready) timeout("return_to_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_total"},   32'(pcm_rx_total),   32'(exp_total));
    check({tag, "_drop"},    32'(pcm_rx_drop),    32'(exp_drop));
    check({tag, "_err"},     32'(pcm_rx_err),     32'(exp_err));
    check({tag, "_channel"}, 32'(pcm_rx_channel), 32'(exp_chan));
  endtask

  // Reference model: predict packet outcome from the payload rules, then send it
  task automatic run_pkt(input logic [7:0] ch, input logic [7:0] typ, input int n,
                         input int len, input int last_idx, input bit gaps, input string tag);
    logic [7:0]  b[$];
    logic [15:0] s[$];
    int          content, nsamp, free_sp;
    b.push_back(ch);
    b.push_back(typ);
    b.push_back(8'((n >> 8) & 3));
    b.push_back(8'(n & 255));
    for (int k = 0; k < n; k++) begin
      s.push_back(16'($urandom));
      b.push_back(s[k][15:8]);
      b.push_back(s[k][7:0]);
    end
    while (b.size() < last_idx + 1) b.push_back(8'($urandom));
    while (b.size() > last_idx + 1) void'(b.pop_back());

    free_sp = DEPTH - exp_q.size();
    content = 4 + 2 * n;
    if (last_idx < 4) begin
      exp_err[0] = 1'b1;
      exp_drop++;
    end else if (typ != 8'he0 || n < 1 || n > 660 || len != 2 * n + 12 || free_sp < n) begin
      exp_drop++;
    end else begin
      exp_chan = ch;
      nsamp = (last_idx < content - 1) ? (last_idx - 3) / 2 : n;
      for (int k = 0; k < nsamp; k++) exp_q.push_back(s[k]);
      exp_total += nsamp;
      if (last_idx < content - 1) begin
        exp_err[0] = 1'b1;
        exp_drop++;
      end else if (last_idx > content - 1) begin
        exp_err[1] = 1'b1;
      end
    end

    send_hdr(16'(len));
    send_bytes(b, gaps);
    wait_idle();
    check_status(tag);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) timeout({tag, "_drain"});
  endtask

  initial begin : main
    int n;
    bus.udp_hdr_valid           = 1'b0;
    bus.udp_length              = 16'd0;
    bus.udp_payload_axis_tdata  = 8'd0;
    bus.udp_payload_axis_tvalid = 1'b0;
    bus.udp_payload_axis_tlast  = 1'b0;
    bus.pcm_out_ready           = 1'b1;
    pcm_rx_clear                = 1'b0;
    rst                         = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_ready", 32'(bus.udp_hdr_ready), 32'd0);
    check("rst_tready",    32'(bus.udp_payload_axis_tready), 32'd0);
    check("rst_out_valid", 32'(bus.pcm_out_valid), 32'd0);
    check("rst_available", 32'(pcm_available), 32'd0);
    check_status("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_hdr_ready", 32'(bus.udp_hdr_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic accepted packet, then wrong type byte
    run_pkt(8'h03, 8'he0, 4, 20, 11, 1'b0, "basic");
    drain("basic");
    run_pkt(8'h03, 8'he1, 4, 20, 11, 1'b0, "badtype");
    // Early tlast after the first sample, then a good packet
    run_pkt(8'h05, 8'he0, 2, 16, 5, 1'b0, "short");
    run_pkt(8'h06, 8'he0, 2, 16, 7, 1'b0, "after_short");
    // Header truncated, bad length, zero and oversized sample counts
    run_pkt(8'h07, 8'he0, 2, 16, 2, 1'b0, "hdr_short");
    run_pkt(8'h08, 8'he0, 2, 18, 7, 1'b0, "badlen");
    run_pkt(8'h09, 8'he0, 0, 12, 3, 1'b0, "zero_n");
    run_pkt(8'h0a, 8'he0, 661, 1334, 1325, 1'b0, "big_n");
    // Missing tlast: trailing bytes swallowed
    run_pkt(8'h0b, 8'he0, 2, 16, 10, 1'b0, "long");
    drain("long");

    // Clear pulse resets the statistics
    pcm_rx_clear = 1'b1;
    @(posedge clk);
    #1;
    pcm_rx_clear = 1'b0;
    exp_total = 0;
    exp_drop  = 0;
    exp_err   = 2'b00;
    @(negedge clk);
    check_status("clear");
    @(posedge clk);
    #1;

    // Fill to DEPTH-3 with backpressure; a 4-sample packet cannot fit
    bus.pcm_out_ready = 1'b0;
    run_pkt(8'h10, 8'he0, 660, 1332, 1323, 1'b0, "fill1");
    run_pkt(8'h11, 8'he0, 361, 734, 725, 1'b0, "fill2");
    @(negedge clk);
    check("fill_available", 32'(pcm_available), 32'(DEPTH - 3));
    @(posedge clk);
    #1;
    run_pkt(8'h12, 8'he0, 4, 20, 11, 1'b0, "full_drop");
    bus.pcm_out_ready = 1'b1;
    drain("fill");
    run_pkt(8'h12, 8'he0, 4, 20, 11, 1'b0, "full_retry");

    // Random backpressure and source gaps over legal packets
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      n = $urandom_range(1, 32);
      for (int t = 0; t < 20000 && exp_q.size() + n > DEPTH; t++) begin
        @(posedge clk);
        #1;
      end
      run_pkt(8'($urandom), 8'he0, n, 2 * n + 12, 3 + 2 * n, 1'b1, "rand");
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.pcm_out_ready = 1'b1;
    drain("final");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("final_available", 32'(pcm_available), 32'd0);
    check("final_out_valid", 32'(bus.pcm_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
